// File: rtl/coso_pkg.sv
// coso_pkg: shared types and default parameters for the COSO entropy-source sequencer.
//   coso_state_e  - sequencer state encoding
//   COSO_*        - default widths, settle time and legal beat-period window
package coso_pkg;

    localparam int unsigned COSO_CNT_W      = 16;
    localparam int unsigned COSO_OUT_W      = 8;
    localparam int unsigned COSO_CNT_MIN    = 4;
    localparam int unsigned COSO_CNT_MAX    = 4095;
    localparam int unsigned COSO_SETTLE_CYC = 1024;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_SYNC   = 3'd2,
        ST_COUNT  = 3'd3,
        ST_ALARM  = 3'd4
    } coso_state_e;

endpackage

// File: rtl/coso_out_buf.sv
// coso_out_buf: one-word valid/ready output buffer with drop detection.
//   clk, rst     - clock, synchronous active-high reset
//   load_i       - a completed word is offered this cycle
//   word_i       - the completed word
//   ovf_clr_i    - clear the sticky overflow flag
//   rnd_ready_i  - consumer accepts the buffered word
//   rnd_data_o   - buffered word, stable while valid and not accepted
//   rnd_valid_o  - buffer holds an unread word
//   ovf_o        - sticky: a completed word was dropped
module coso_out_buf
    import coso_pkg::*;
#(
    parameter int unsigned OUT_W = COSO_OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [OUT_W-1:0] word_i,
    input  logic             ovf_clr_i,
    input  logic             rnd_ready_i,
    output logic [OUT_W-1:0] rnd_data_o,
    output logic             rnd_valid_o,
    output logic             ovf_o
);

    logic [OUT_W-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             accept_c;
    logic             room_c;

    assign accept_c = valid_q & rnd_ready_i;
    // A word being read this cycle frees the slot for a same-cycle load.
    assign room_c   = ~valid_q | accept_c;

    // Next buffer contents: load, drop or drain.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q & ~accept_c;
        ovf_d   = ovf_q & ~ovf_clr_i;
        if (load_i) begin
            if (room_c) begin
                data_d  = word_i;
                valid_d = 1'b1;
            end else begin
                ovf_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign rnd_data_o  = data_q;
    assign rnd_valid_o = valid_q;
    assign ovf_o       = ovf_q;

endmodule

// File: rtl/coso_sample_ctrl.sv
// coso_sample_ctrl: COSO sequencer - enables the ring oscillators, waits for
// settling, measures the beat period and packs period LSBs into output words.
//   clk, rst   - clock, synchronous active-high reset
//   start      - level enable (high = run, low = return to idle)
//   beat_in    - beat signal, already synchronized to clk
//   ro_en      - ring oscillator enable
//   rnd_data   - random word, first collected bit in the MSB
//   rnd_valid  - rnd_data holds an unread word
//   rnd_ready  - consumer accepts the word
//   alarm      - sticky lock-in/stall alarm, cleared on the next SETTLE entry
//   ovf        - sticky dropped-word flag, cleared on the next SETTLE entry
//   busy       - sequencer not idle
module coso_sample_ctrl
    import coso_pkg::*;
#(
    parameter int unsigned CNT_W      = COSO_CNT_W,
    parameter int unsigned SETTLE_CYC = COSO_SETTLE_CYC,
    parameter int unsigned CNT_MIN    = COSO_CNT_MIN,
    parameter int unsigned CNT_MAX    = COSO_CNT_MAX,
    parameter int unsigned OUT_W      = COSO_OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             beat_in,
    output logic             ro_en,
    output logic [OUT_W-1:0] rnd_data,
    output logic             rnd_valid,
    input  logic             rnd_ready,
    output logic             alarm,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned BIT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    coso_state_e      state_q, state_d;
    logic             beat_q;
    logic             edge_q;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-2:0] sh_q, sh_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic             ro_en_q, ro_en_d;
    logic             busy_q, busy_d;
    logic             alarm_q, alarm_d;

    logic             settle_done_c;
    logic             short_c;
    logic             cnt_max_c;
    logic             run_c;
    logic             load_c;
    logic             ovf_clr_c;
    logic [OUT_W-1:0] word_c;

    assign settle_done_c = (settle_q == SET_W'(SETTLE_CYC - 1));
    assign short_c       = (cnt_q < CNT_W'(CNT_MIN));
    assign cnt_max_c     = (cnt_q >= CNT_W'(CNT_MAX));
    assign run_c         = (state_q == ST_SETTLE) || (state_q == ST_SYNC) ||
                           (state_q == ST_COUNT);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!start)             state_d = ST_IDLE;
                else if (settle_done_c) state_d = ST_SYNC;
            end
            ST_SYNC: begin
                if (!start)      state_d = ST_IDLE;
                else if (edge_q) state_d = ST_COUNT;
            end
            ST_COUNT: begin
                // An edge on the CNT_MAX cycle is a legal period, so it is checked first.
                if (!start) begin
                    state_d = ST_IDLE;
                end else if (edge_q) begin
                    if (short_c) state_d = ST_ALARM;
                end else if (cnt_max_c) begin
                    state_d = ST_ALARM;
                end
            end
            ST_ALARM: begin
                if (!start) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath control.
    always_comb begin
        settle_d  = settle_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        bit_d     = bit_q;
        load_c    = 1'b0;
        ovf_clr_c = 1'b0;
        word_c    = {sh_q, cnt_q[0]};

        case (state_q)
            ST_IDLE: begin
                settle_d  = '0;
                cnt_d     = '0;
                sh_d      = '0;
                bit_d     = '0;
                ovf_clr_c = start;
            end
            ST_SETTLE: begin
                settle_d = settle_q + SET_W'(1);
            end
            ST_SYNC: begin
                // The first edge only opens the measurement window.
                if (edge_q) cnt_d = CNT_W'(1);
            end
            ST_COUNT: begin
                if (edge_q) begin
                    if (!short_c) begin
                        cnt_d = CNT_W'(1);
                        if (bit_q == BIT_W'(OUT_W - 1)) begin
                            load_c = 1'b1;
                            sh_d   = '0;
                            bit_d  = '0;
                        end else begin
                            sh_d  = word_c[OUT_W-2:0];
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end
                end else if (!cnt_max_c) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase

        // Stopping discards the partial word; a buffered word is untouched.
        if (run_c && !start) begin
            load_c = 1'b0;
            sh_d   = '0;
            bit_d  = '0;
        end

        ro_en_d = (state_d == ST_SETTLE) || (state_d == ST_SYNC) ||
                  (state_d == ST_COUNT);
        busy_d  = (state_d != ST_IDLE);
        alarm_d = alarm_q;
        if (state_d == ST_ALARM)       alarm_d = 1'b1;
        else if (state_d == ST_SETTLE) alarm_d = 1'b0;
    end

    // Edge detector, counters, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q   <= 1'b0;
            edge_q   <= 1'b0;
            settle_q <= '0;
            cnt_q    <= '0;
            sh_q     <= '0;
            bit_q    <= '0;
            ro_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            alarm_q  <= 1'b0;
        end else begin
            beat_q   <= beat_in;
            edge_q   <= beat_in & ~beat_q;
            settle_q <= settle_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            bit_q    <= bit_d;
            ro_en_q  <= ro_en_d;
            busy_q   <= busy_d;
            alarm_q  <= alarm_d;
        end
    end

    coso_out_buf #(
        .OUT_W (OUT_W)
    ) u_out_buf (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load_c),
        .word_i      (word_c),
        .ovf_clr_i   (ovf_clr_c),
        .rnd_ready_i (rnd_ready),
        .rnd_data_o  (rnd_data),
        .rnd_valid_o (rnd_valid),
        .ovf_o       (ovf)
    );

    assign ro_en = ro_en_q;
    assign busy  = busy_q;
    assign alarm = alarm_q;

endmodule

// File: tb/tb_coso_sample_ctrl.sv
// tb_coso_sample_ctrl: self-checking bench for coso_sample_ctrl.
// Beat rises are generated at exact cycle spacings; expected words come from a
// table of period patterns and are queued for a monitor that checks accepted words.
module tb_coso_sample_ctrl;

    localparam int unsigned N = 1024;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       beat_in;
    logic       ro_en;
    logic [7:0] rnd_data;
    logic       rnd_valid;
    logic       rnd_ready;
    logic       alarm;
    logic       ovf;
    logic       busy;

    coso_sample_ctrl #(
        .CNT_W      (16),
        .SETTLE_CYC (N),
        .CNT_MIN    (4),
        .CNT_MAX    (4095),
        .OUT_W      (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .beat_in   (beat_in),
        .ro_en     (ro_en),
        .rnd_data  (rnd_data),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .alarm     (alarm),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         p[8];
        logic [7:0] word;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] exp_q[$];
    logic [7:0] exp_w;
    int         n_chk  = 0;
    int         n_fail = 0;

    bit         pend = 1'b0;
    logic       pv;
    logic [7:0] pd;
    logic       po;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Word-completion check to be made one cycle after the completing rise is sampled.
    task automatic post_check(input logic v, input logic [7:0] d, input logic o);
        pend = 1'b1;
        pv   = v;
        pd   = d;
        po   = o;
    endtask

    task automatic do_pending();
        if (pend) begin
            chk("word_valid", 16'(rnd_valid), 16'(pv));
            if (pv) chk("word_data", 16'(rnd_data), 16'(pd));
            chk("word_ovf", 16'(ovf), 16'(po));
            pend = 1'b0;
        end
    endtask

    task automatic flush();
        if (pend) begin
            tick();
            do_pending();
        end
    endtask

    task automatic pulse();
        beat_in = 1'b1;
        tick();
        beat_in = 1'b0;
    endtask

    // Next beat rise exactly p cycles after the previous one.
    task automatic period(input int p);
        for (int i = 0; i < p - 1; i++) begin
            tick();
            if (i == 0) do_pending();
        end
        pulse();
    endtask

    always @(negedge clk) begin
        if (!rst && rnd_valid && rnd_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_unexpected: got word 0x%0h, expected none", rnd_data);
            end else begin
                exp_w = exp_q.pop_front();
                chk("sb_word", 16'(rnd_data), 16'(exp_w));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;

        vecs[0].p = '{7, 10, 7, 10, 7, 10, 7, 10};   vecs[0].word = 8'hAA;
        vecs[1].p = '{4, 4, 4, 4, 4, 4, 4, 4};       vecs[1].word = 8'h00;
        vecs[2].p = '{5, 5, 5, 5, 5, 5, 5, 5};       vecs[2].word = 8'hFF;
        vecs[3].p = '{5, 6, 4, 9, 11, 8, 13, 20};    vecs[3].word = 8'h9A;
        vecs[4].p = '{4095, 4, 4, 4, 4, 4, 4, 5};    vecs[4].word = 8'h81;
        vecs[5].p = '{6, 7, 8, 9, 10, 11, 12, 13};   vecs[5].word = 8'h55;

        rst       = 1'b1;
        start     = 1'b0;
        beat_in   = 1'b0;
        rnd_ready = 1'b0;
        repeat (3) tick();
        chk("rst_ro_en", 16'(ro_en), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_valid", 16'(rnd_valid), 16'd0);
        chk("rst_data", 16'(rnd_data), 16'd0);
        chk("rst_alarm", 16'(alarm), 16'd0);
        chk("rst_ovf", 16'(ovf), 16'd0);
        rst = 1'b0;
        tick();
        chk("idle_busy", 16'(busy), 16'd0);

        // Normal run through the period table, consumer always ready.
        start = 1'b1;
        tick();
        chk("start_ro_en", 16'(ro_en), 16'd1);
        chk("start_busy", 16'(busy), 16'd1);
        repeat (N - 1) tick();
        pulse();
        rnd_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            for (int b = 0; b < 8; b++) begin
                period(vecs[v].p[b]);
                if (b == 7) begin
                    post_check(1'b1, vecs[v].word, 1'b0);
                    exp_q.push_back(vecs[v].word);
                end
            end
        end

        // Abort after 5 bits with a buffered word.
        flush();
        tick();
        rnd_ready = 1'b0;
        period(3);
        repeat (7) period(5);
        post_check(1'b1, 8'hFF, 1'b0);
        exp_q.push_back(8'hFF);
        repeat (5) period(4);
        tick();
        start = 1'b0;
        tick();
        chk("abort_busy", 16'(busy), 16'd0);
        chk("abort_ro_en", 16'(ro_en), 16'd0);
        chk("abort_valid", 16'(rnd_valid), 16'd1);
        chk("abort_data", 16'(rnd_data), 16'hFF);
        rnd_ready = 1'b1;
        tick();
        rnd_ready = 1'b0;
        chk("abort_drained", 16'(rnd_valid), 16'd0);

        // Backpressure: first word held, second dropped; partial bits were lost.
        start = 1'b1;
        tick();
        chk("restart_ovf", 16'(ovf), 16'd0);
        repeat (N - 1) tick();
        pulse();
        for (int b = 0; b < 8; b++) begin
            period((b % 2 == 0) ? 5 : 4);
            if (b == 2) post_check(1'b0, 8'h00, 1'b0);
            if (b == 7) post_check(1'b1, 8'hAA, 1'b0);
        end
        repeat (8) period(4);
        post_check(1'b1, 8'hAA, 1'b1);
        flush();
        rnd_ready = 1'b1;
        exp_q.push_back(8'hAA);
        tick();
        rnd_ready = 1'b0;
        chk("bp_drained", 16'(rnd_valid), 16'd0);
        chk("bp_ovf_sticky", 16'(ovf), 16'd1);
        start = 1'b0;
        tick();

        // Same-cycle accept and load: no overflow.
        start = 1'b1;
        tick();
        chk("restart2_ovf", 16'(ovf), 16'd0);
        repeat (N - 1) tick();
        pulse();
        repeat (8) period(5);
        post_check(1'b1, 8'hFF, 1'b0);
        exp_q.push_back(8'hFF);
        repeat (8) period(4);
        rnd_ready = 1'b1;
        exp_q.push_back(8'h00);
        post_check(1'b1, 8'h00, 1'b0);
        flush();
        tick();
        rnd_ready = 1'b0;

        // Reset mid-operation with a valid word and ovf set.
        period(3);
        repeat (15) period(5);
        tick();
        chk("pre_rst_valid", 16'(rnd_valid), 16'd1);
        chk("pre_rst_ovf", 16'(ovf), 16'd1);
        rst   = 1'b1;
        start = 1'b0;
        tick();
        chk("midrst_ro_en", 16'(ro_en), 16'd0);
        chk("midrst_busy", 16'(busy), 16'd0);
        chk("midrst_valid", 16'(rnd_valid), 16'd0);
        chk("midrst_data", 16'(rnd_data), 16'd0);
        chk("midrst_alarm", 16'(alarm), 16'd0);
        chk("midrst_ovf", 16'(ovf), 16'd0);
        rst = 1'b0;
        tick();

        // Edge in the last SETTLE cycle is ignored; then a 3-cycle period is lock-in.
        start = 1'b1;
        tick();
        repeat (N - 2) tick();
        pulse();
        period(3);
        period(3);
        chk("lock_not_early", 16'(alarm), 16'd0);
        tick();
        chk("lock_alarm", 16'(alarm), 16'd1);
        chk("lock_ro_en", 16'(ro_en), 16'd0);
        chk("lock_busy", 16'(busy), 16'd1);
        repeat (5) tick();
        chk("lock_hold_alarm", 16'(alarm), 16'd1);
        chk("lock_hold_busy", 16'(busy), 16'd1);
        start = 1'b0;
        tick();
        chk("lock_idle_busy", 16'(busy), 16'd0);
        chk("lock_idle_alarm", 16'(alarm), 16'd1);
        start = 1'b1;
        tick();
        chk("lock_resettle_alarm", 16'(alarm), 16'd0);
        chk("lock_resettle_ro_en", 16'(ro_en), 16'd1);
        chk("lock_no_word", 16'(rnd_valid), 16'd0);

        // Stall: beat held low after the sync edge.
        repeat (N - 1) tick();
        pulse();
        cyc = 0;
        while (!alarm && cyc < 5000) begin
            tick();
            cyc++;
        end
        chk("stall_cycles", 16'(cyc), 16'd4096);
        chk("stall_no_word", 16'(rnd_valid), 16'd0);
        chk("stall_ro_en", 16'(ro_en), 16'd0);
        start = 1'b0;
        tick();

        chk("sb_empty", 16'(exp_q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
